cnn_load_sequencer: RTL

//  Parametrised load sequencer for one CNN layer. On start it fetches num_filters

---
 rtl/cnn_load_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cnn_load_sequencer.sv
// rtl/cnn_load_sequencer.sv - burst load sequencer for CNN filter kernels and one image plane
// Optional stall_cycles performance counter port: define CNN_SEQ_PERF_EN.
module cnn_load_sequencer #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 150,
  parameter int FLT_WORDS   = 25,
  parameter int MAX_FILTERS = 16,
  parameter int IMG_WORDS   = 1024,
  parameter int LEN_W       = $clog2(BURST_LEN + 1),
  parameter int CH_W        = $clog2(MAX_FILTERS + 1),
  parameter int IA_W        = $clog2(IMG_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] flt_base,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [CH_W-1:0]   num_filters,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rready,
  output logic              flt_wr,
  output logic [DATA_W-1:0] flt_data,
  input  logic              flt_full,
  output logic              img_wr,
  output logic [IA_W-1:0]   img_addr,
  output logic [DATA_W-1:0] img_data,
  output logic              busy,
  output logic              done
`ifdef CNN_SEQ_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int FLT_MAX = MAX_FILTERS * FLT_WORDS;
  localparam int RW      = $clog2(((FLT_MAX > IMG_WORDS) ? FLT_MAX : IMG_WORDS) + 1);

  typedef enum logic [2:0] {IDLE, FLT_REQ, FLT_DATA, IMG_REQ, IMG_DATA, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] flt_base_q;
  logic [ADDR_W-1:0] img_base_q;
  logic [ADDR_W-1:0] req_off;
  logic [RW-1:0]     rem;
  logic [LEN_W-1:0]  beats;
  logic [IA_W-1:0]   img_idx;
  logic [RW-1:0]     flt_total;
  logic              beat;
  logic              last_beat;

  function automatic logic [LEN_W-1:0] chunk(input logic [RW-1:0] r);
    if (32'(r) >= BURST_LEN) return LEN_W'(BURST_LEN);
    return LEN_W'(r);
  endfunction

  assign flt_total = RW'(num_filters) * RW'(FLT_WORDS);

  // Reset gates ready directly so no beat can be taken in the reset cycle itself.
  always_comb begin
    mem_rready = 1'b0;
    if (!reset) begin
      if (state == FLT_DATA)      mem_rready = !flt_full;
      else if (state == IMG_DATA) mem_rready = 1'b1;
    end
  end

  assign beat      = mem_rvalid && mem_rready;
  assign last_beat = beat && (beats == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      flt_base_q <= '0;
      img_base_q <= '0;
      req_off    <= '0;
      rem        <= '0;
      beats      <= '0;
      img_idx    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_len    <= '0;
      flt_wr     <= 1'b0;
      flt_data   <= '0;
      img_wr     <= 1'b0;
      img_addr   <= '0;
      img_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      flt_wr <= 1'b0;
      img_wr <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            flt_base_q <= flt_base;
            img_base_q <= img_base;
            req_off    <= '0;
            img_idx    <= '0;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            if (num_filters == '0) begin
              state    <= IMG_REQ;
              rem      <= RW'(IMG_WORDS);
              mem_addr <= img_base;
              mem_len  <= chunk(RW'(IMG_WORDS));
            end else begin
              state    <= FLT_REQ;
              rem      <= flt_total;
              mem_addr <= flt_base;
              mem_len  <= chunk(flt_total);
            end
          end
        end
        FLT_REQ, IMG_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            beats   <= mem_len;
            rem     <= rem - RW'(mem_len);
            req_off <= req_off + ADDR_W'(mem_len);
            state   <= (state == FLT_REQ) ? FLT_DATA : IMG_DATA;
          end
        end
        FLT_DATA: begin
          if (beat) begin
            flt_wr   <= 1'b1;
            flt_data <= mem_rdata;
            beats    <= beats - LEN_W'(1);
          end
          if (last_beat) begin
            mem_req <= 1'b1;
            if (rem != '0) begin
              state    <= FLT_REQ;
              mem_addr <= flt_base_q + req_off;
              mem_len  <= chunk(rem);
            end else begin
              state    <= IMG_REQ;
              rem      <= RW'(IMG_WORDS);
              req_off  <= '0;
              mem_addr <= img_base_q;
              mem_len  <= chunk(RW'(IMG_WORDS));
            end
          end
        end
        IMG_DATA: begin
          if (beat) begin
            img_wr   <= 1'b1;
            img_addr <= img_idx;
            img_data <= mem_rdata;
            img_idx  <= img_idx + IA_W'(1);
            beats    <= beats - LEN_W'(1);
          end
          if (last_beat) begin
            if (rem != '0) begin
              state    <= IMG_REQ;
              mem_req  <= 1'b1;
              mem_addr <= img_base_q + req_off;
              mem_len  <= chunk(rem);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CNN_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (state == IDLE && start)
      stall_cycles <= '0;
    else if (busy && mem_rvalid && !mem_rready && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
